score_keeper: RTL and testbench

//  Synchronous, parametrised N-player score tracker for the Pong datapath.

---
 rtl/pong_pkg.sv | 28 ++
 rtl/bcd_counter.sv | 76 +++++++
 rtl/score_keeper.sv | 157 +++++++++++++++
 tb/tb_score_keeper.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and sizing helpers for the Pong score datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

  // Score FSM states
  typedef enum logic [1:0] {
    PLAY = 2'd0,
    HOLD = 2'd1,
    OVER = 2'd2
  } score_state_t;

  // One BCD digit
  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // Binary width able to hold 10^digits-1
  function automatic int score_width(input int digits);
    return $clog2(10 ** digits);
  endfunction

  // Width of a player index, never below one bit
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating multi-digit BCD counter with a lock-step binary count.
// Latency: bcd/bin update on the edge after inc/clr; bin_nxt is combinational.
// Backpressure: none; inc at all-9s is absorbed (count holds).
module bcd_counter
  import pong_pkg::*;
#(
  parameter int DIGITS = 2,
  localparam int W = score_width(DIGITS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [DIGITS*4-1:0] bcd,
  output logic [W-1:0]      bin,
  output logic [W-1:0]      bin_nxt
);

  bcd_digit_t dig_q [DIGITS];
  bcd_digit_t dig_d [DIGITS];
  logic [W-1:0] bin_q;
  logic [W-1:0] bin_d;
  logic all_nine;
  logic carry;

  // All digits at 9 means the count is saturated
  always_comb begin
    all_nine = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_q[i] != BCD_NINE) all_nine = 1'b0;
    end
  end

  // Next-count logic: clear wins, otherwise ripple a carry from the LS digit
  always_comb begin
    dig_d = dig_q;
    bin_d = bin_q;
    carry = 1'b0;
    if (clr) begin
      for (int i = 0; i < DIGITS; i++) dig_d[i] = '0;
      bin_d = '0;
    end else if (inc && !all_nine) begin
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (dig_q[i] == BCD_NINE) begin
            dig_d[i] = '0;
          end else begin
            dig_d[i] = dig_q[i] + 4'd1;
            carry    = 1'b0;
          end
        end
      end
      bin_d = bin_q + 1'b1;
    end
  end

  // Count registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DIGITS; i++) dig_q[i] <= '0;
      bin_q <= '0;
    end else begin
      dig_q <= dig_d;
      bin_q <= bin_d;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_out
    assign bcd[g*4 +: 4] = dig_q[g];
  end

  assign bin     = bin_q;
  assign bin_nxt = bin_d;

endmodule

// File: rtl/score_keeper.sv
// N-player Pong score tracker: synchronises strobes, credits points, detects the winner.
// Latency: score_bcd/point_pulse update on the 3rd clk edge after a strobe rises.
// Backpressure: none; strobes during HOLD/OVER or losing a same-cycle tie are dropped.
module score_keeper
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int DIGITS      = 2,
  parameter int WIN_SCORE   = 11,
  parameter int WIN_BY_TWO  = 1,
  parameter int HOLD_CYCLES = 1000,
  localparam int SW = score_width(DIGITS),
  localparam int WW = index_width(NUM_PLAYERS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PLAYERS-1:0]        score_in,
  input  logic                          new_game,
  output logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd,
  output logic                          point_pulse,
  output logic                          serve_ready,
  output logic                          game_over,
  output logic [WW-1:0]                 winner
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [SW:0]   WIN_VAL   = (SW+1)'(WIN_SCORE);
  localparam logic [SW:0]   LEAD_MIN  = (SW+1)'(2);

  score_state_t state;
  logic [HW-1:0] hold_cnt;

  logic [NUM_PLAYERS-1:0] sync1;
  logic [NUM_PLAYERS-1:0] sync2;
  logic [NUM_PLAYERS-1:0] prev;
  logic [NUM_PLAYERS-1:0] edges;
  logic [NUM_PLAYERS-1:0] inc;
  logic                   hit;
  logic [WW-1:0]          sel;
  logic                   win;

  logic [SW-1:0] bin_q   [NUM_PLAYERS];
  logic [SW-1:0] bin_nxt [NUM_PLAYERS];

  // Two-flop synchroniser plus one delay flop for rising-edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= score_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edges = sync2 & ~prev;

  // Grant the lowest-index edge, only while in PLAY and not being cleared
  always_comb begin
    inc = '0;
    hit = 1'b0;
    sel = '0;
    if (state == PLAY && !new_game) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (edges[i] && !hit) begin
          inc[i] = 1'b1;
          hit    = 1'b1;
          sel    = WW'(i);
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_player
    bcd_counter #(.DIGITS(DIGITS)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[g]),
      .clr     (new_game),
      .bcd     (score_bcd[g*DIGITS*4 +: DIGITS*4]),
      .bin     (bin_q[g]),
      .bin_nxt (bin_nxt[g])
    );
  end

  // Win check on the scorer's post-increment value; other players are unchanged this cycle
  always_comb begin
    win = 1'b0;
    if (hit) begin
      win = ({1'b0, bin_nxt[sel]} >= WIN_VAL);
      if (WIN_BY_TWO != 0) begin
        for (int j = 0; j < NUM_PLAYERS; j++) begin
          if (WW'(j) != sel && ({1'b0, bin_nxt[sel]} < ({1'b0, bin_q[j]} + LEAD_MIN)))
            win = 1'b0;
        end
      end
    end
  end

  // Game FSM with serve-hold counter and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= PLAY;
      hold_cnt    <= '0;
      point_pulse <= 1'b0;
      serve_ready <= 1'b1;
      game_over   <= 1'b0;
      winner      <= '0;
    end else begin
      point_pulse <= 1'b0;
      if (new_game) begin
        state       <= PLAY;
        hold_cnt    <= '0;
        serve_ready <= 1'b1;
        game_over   <= 1'b0;
        winner      <= '0;
      end else begin
        case (state)
          PLAY: begin
            if (hit) begin
              point_pulse <= 1'b1;
              serve_ready <= 1'b0;
              if (win) begin
                state     <= OVER;
                game_over <= 1'b1;
                winner    <= sel;
              end else begin
                state    <= HOLD;
                hold_cnt <= HOLD_LOAD;
              end
            end
          end
          HOLD: begin
            if (hold_cnt == '0) begin
              state       <= PLAY;
              serve_ready <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          OVER: begin
            state <= OVER;
          end
          default: begin
            state       <= PLAY;
            serve_ready <= 1'b1;
            game_over   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Directed, table-driven bench for score_keeper across three parameter sets.
// Latency: checks land #1 after the crediting edge.
// Backpressure: n/a.
module tb_score_keeper;

  localparam int HOLD_A = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [1:0]  sin_a = '0, sin_b = '0, sin_c = '0;
  logic        ng_a = 1'b0, ng_b = 1'b0, ng_c = 1'b0;
  logic [15:0] bcd_a;
  logic [7:0]  bcd_b, bcd_c;
  logic        pp_a, pp_b, pp_c;
  logic        sr_a, sr_b, sr_c;
  logic        go_a, go_b, go_c;
  logic        win_a, win_b, win_c;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(11), .WIN_BY_TWO(1), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .reset(reset), .score_in(sin_a), .new_game(ng_a), .score_bcd(bcd_a),
    .point_pulse(pp_a), .serve_ready(sr_a), .game_over(go_a), .winner(win_a));

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(1), .WIN_SCORE(9), .WIN_BY_TWO(0), .HOLD_CYCLES(4)) dut_b (
    .clk(clk), .reset(reset), .score_in(sin_b), .new_game(ng_b), .score_bcd(bcd_b),
    .point_pulse(pp_b), .serve_ready(sr_b), .game_over(go_b), .winner(win_b));

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(1), .WIN_SCORE(9), .WIN_BY_TWO(1), .HOLD_CYCLES(4)) dut_c (
    .clk(clk), .reset(reset), .score_in(sin_c), .new_game(ng_c), .score_bcd(bcd_c),
    .point_pulse(pp_c), .serve_ready(sr_c), .game_over(go_c), .winner(win_c));

  typedef struct {
    int          dut;
    logic [1:0]  mask;
    int          rep;
    logic [15:0] bcd;
    logic        pp;
    logic        go;
    logic        win;
  } vec_t;

  vec_t tbl [19];

  function automatic logic [15:0] get_bcd(input int d);
    case (d)
      0:       return bcd_a;
      1:       return {8'h00, bcd_b};
      default: return {8'h00, bcd_c};
    endcase
  endfunction

  function automatic logic get_pp(input int d);
    case (d)
      0: return pp_a; 1: return pp_b; default: return pp_c;
    endcase
  endfunction

  function automatic logic get_sr(input int d);
    case (d)
      0: return sr_a; 1: return sr_b; default: return sr_c;
    endcase
  endfunction

  function automatic logic get_go(input int d);
    case (d)
      0: return go_a; 1: return go_b; default: return go_c;
    endcase
  endfunction

  function automatic logic get_win(input int d);
    case (d)
      0: return win_a; 1: return win_b; default: return win_c;
    endcase
  endfunction

  task automatic set_in(input int d, input logic [1:0] m);
    case (d)
      0: sin_a = m; 1: sin_b = m; default: sin_c = m;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else
      passed++;
  endtask

  // Raise the strobe and return #1 after the 3rd edge, where the credit lands
  task automatic pulse_to_credit(input int d, input logic [1:0] m);
    @(negedge clk);
    set_in(d, m);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Drop the strobe and wait (bounded) until the DUT can take the next point
  task automatic settle(input int d);
    int n;
    @(negedge clk);
    set_in(d, 2'b00);
    if (get_go(d)) begin
      repeat (4) @(posedge clk);
    end else begin
      n = 0;
      while (!get_sr(d) && n < 200) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("serve_ready_return", {31'd0, get_sr(d)}, 32'd1);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int ppseen;

    tbl[0]  = '{0, 2'b11, 1, 16'h0102, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{0, 2'b01, 7, 16'h0109, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{0, 2'b01, 1, 16'h0110, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{0, 2'b10, 9, 16'h1010, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{0, 2'b01, 1, 16'h1011, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{0, 2'b01, 1, 16'h1012, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{0, 2'b10, 1, 16'h1012, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1, 2'b10, 1, 16'h0010, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1, 2'b01, 1, 16'h0011, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1, 2'b11, 1, 16'h0012, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1, 2'b10, 7, 16'h0082, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1, 2'b10, 1, 16'h0092, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1, 2'b01, 1, 16'h0092, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{2, 2'b01, 8, 16'h0008, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{2, 2'b10, 8, 16'h0088, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{2, 2'b01, 1, 16'h0089, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{2, 2'b10, 1, 16'h0099, 1'b1, 1'b0, 1'b0};
    tbl[17] = '{2, 2'b01, 1, 16'h0099, 1'b1, 1'b0, 1'b0};
    tbl[18] = '{2, 2'b10, 1, 16'h0099, 1'b1, 1'b0, 1'b0};

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_bcd", {16'd0, get_bcd(d)}, 32'd0);
      chk("rst_pp",  {31'd0, get_pp(d)},  32'd0);
      chk("rst_sr",  {31'd0, get_sr(d)},  32'd1);
      chk("rst_go",  {31'd0, get_go(d)},  32'd0);
      chk("rst_win", {31'd0, get_win(d)}, 32'd0);
    end
    reset = 1'b0;
    repeat (3) @(posedge clk);

    // First point: exact 3-edge latency, one-cycle pulse, HOLD length, edge dropped in HOLD
    @(negedge clk);
    sin_a = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    chk("lat_e2_bcd", {16'd0, bcd_a}, 32'd0);
    chk("lat_e2_pp",  {31'd0, pp_a},  32'd0);
    @(posedge clk);
    #1;
    chk("lat_e3_bcd", {16'd0, bcd_a}, 32'h0001);
    chk("lat_e3_pp",  {31'd0, pp_a},  32'd1);
    chk("lat_e3_sr",  {31'd0, sr_a},  32'd0);
    lowcnt = 1;
    ppseen = 0;
    @(negedge clk);
    sin_a = 2'b00;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (pp_a) ppseen++;
      if (sr_a) break;
      lowcnt++;
      if (i == 1) sin_a = 2'b10;
      if (i == 4) sin_a = 2'b00;
    end
    chk("hold_len",      lowcnt, HOLD_A);
    chk("hold_pp_count", ppseen, 0);
    chk("hold_discard",  {16'd0, bcd_a}, 32'h0001);
    repeat (3) @(posedge clk);

    pulse_to_credit(0, 2'b10);
    chk("p1_after_hold_bcd", {16'd0, bcd_a}, 32'h0101);
    chk("p1_after_hold_pp",  {31'd0, pp_a},  32'd1);
    settle(0);

    // Table of scoring events
    for (int k = 0; k < 19; k++) begin
      for (int r = 0; r < tbl[k].rep; r++) begin
        pulse_to_credit(tbl[k].dut, tbl[k].mask);
        if (r == tbl[k].rep - 1) begin
          chk($sformatf("vec%0d_bcd", k), {16'd0, get_bcd(tbl[k].dut)}, {16'd0, tbl[k].bcd});
          chk($sformatf("vec%0d_pp", k),  {31'd0, get_pp(tbl[k].dut)},  {31'd0, tbl[k].pp});
          chk($sformatf("vec%0d_sr", k),  {31'd0, get_sr(tbl[k].dut)},  32'd0);
          chk($sformatf("vec%0d_go", k),  {31'd0, get_go(tbl[k].dut)},  {31'd0, tbl[k].go});
          chk($sformatf("vec%0d_win", k), {31'd0, get_win(tbl[k].dut)}, {31'd0, tbl[k].win});
        end
        settle(tbl[k].dut);
      end
    end

    // new_game out of OVER
    @(negedge clk);
    ng_a = 1'b1;
    ng_b = 1'b1;
    @(posedge clk);
    #1;
    ng_a = 1'b0;
    ng_b = 1'b0;
    chk("ng_a_bcd", {16'd0, bcd_a}, 32'd0);
    chk("ng_a_go",  {31'd0, go_a},  32'd0);
    chk("ng_a_sr",  {31'd0, sr_a},  32'd1);
    chk("ng_b_bcd", {24'd0, bcd_b}, 32'd0);
    chk("ng_b_win", {31'd0, win_b}, 32'd0);
    chk("ng_b_go",  {31'd0, go_b},  32'd0);
    repeat (3) @(posedge clk);

    // new_game in the same cycle as an edge: the edge is discarded
    @(negedge clk);
    sin_a = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    ng_a = 1'b1;
    @(posedge clk);
    #1;
    ng_a = 1'b0;
    chk("ng_edge_bcd", {16'd0, bcd_a}, 32'd0);
    chk("ng_edge_pp",  {31'd0, pp_a},  32'd0);
    chk("ng_edge_sr",  {31'd0, sr_a},  32'd1);
    settle(0);
    chk("ng_edge_after_bcd", {16'd0, bcd_a}, 32'd0);

    // Asynchronous reset in the middle of HOLD
    pulse_to_credit(0, 2'b01);
    chk("pre_rst_bcd", {16'd0, bcd_a}, 32'h0001);
    @(posedge clk);
    #3;
    reset = 1'b1;
    sin_a = 2'b00;
    #1;
    chk("arst_bcd", {16'd0, bcd_a}, 32'd0);
    chk("arst_sr",  {31'd0, sr_a},  32'd1);
    chk("arst_pp",  {31'd0, pp_a},  32'd0);
    chk("arst_go",  {31'd0, go_a},  32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("post_rst_bcd", {16'd0, bcd_a}, 32'd0);
    chk("post_rst_sr",  {31'd0, sr_a},  32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
